// File: rtl/euler_step_sequencer_pkg.sv
// Shared types for the Euler step sequencer: FSM state encoding and default step-count width.
package euler_pkg;

  localparam int CNT_W_DEFAULT = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    CHECK,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/euler_step_sequencer_ack_watchdog.sv
// Ack watchdog for the Euler sequencer: counts WAIT cycles without ack and flags expiry.
// Only built when EULER_TIMEOUT_EN is defined.
`ifdef EULER_TIMEOUT_EN
module euler_ack_watchdog
  import euler_pkg::*;
#(
  parameter int TMO_CYC = 255,
  parameter int TMO_W   = 8
) (
  input  logic clk,
  input  logic rest_async_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rest_async_n) begin
    if (!rest_async_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the cycle whose increment would reach TMO_CYC.
  assign expired = run && (cnt_q == TMO_W'(TMO_CYC - 1));

endmodule
`endif

// File: rtl/euler_step_sequencer.sv
// Control FSM sequencing a fixed number of Euler steps against an external step counter.
// Optional ack timeout with sticky err and ERROR state under EULER_TIMEOUT_EN.
module euler_step_sequencer
  import euler_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int TMO_CYC = 255,
  parameter int TMO_W   = 8
) (
  input  logic             clk,
  input  logic             rest_async_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             cnt_sync_clr,
  output logic             cnt_en,
  output logic             dp_req,
  output logic             dp_last,
  input  logic             dp_ack,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_steps_q, num_steps_d;
  logic             cnt_sync_clr_q, cnt_sync_clr_d;
  logic             cnt_en_q, cnt_en_d;
  logic             dp_req_q, dp_req_d;
  logic             dp_last_q, dp_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef EULER_TIMEOUT_EN
  logic err_q, err_d;
  logic wd_clr, wd_run, wd_expired;

  assign wd_clr = (state_q == ISSUE);
  assign wd_run = (state_q == WAIT) && dp_req_q && !dp_ack;

  euler_ack_watchdog #(
    .TMO_CYC (TMO_CYC),
    .TMO_W   (TMO_W)
  ) u_ack_watchdog (
    .clk          (clk),
    .rest_async_n (rest_async_n),
    .clr          (wd_clr),
    .run          (wd_run),
    .expired      (wd_expired)
  );
`endif

  always_comb begin
    state_d        = state_q;
    num_steps_d    = num_steps_q;
    cnt_sync_clr_d = 1'b0;
    cnt_en_d       = 1'b0;
    dp_req_d       = dp_req_q;
    dp_last_d      = dp_last_q;
    done_d         = 1'b0;
`ifdef EULER_TIMEOUT_EN
    err_d          = err_q;
`endif
    if (abort) begin
      state_d        = IDLE;
      cnt_sync_clr_d = 1'b1;
      dp_req_d       = 1'b0;
      dp_last_d      = 1'b0;
`ifdef EULER_TIMEOUT_EN
      err_d          = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            num_steps_d    = num_steps;
            cnt_sync_clr_d = 1'b1;
            state_d        = CLEAR;
          end
        end
        // The counter is cleared by this edge, so the first step's last flag
        // comes from num_steps_q alone rather than the stale cnt_value.
        CLEAR: begin
          if (num_steps_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ISSUE;
            dp_req_d  = 1'b1;
            dp_last_d = (num_steps_q == CNT_W'(1));
          end
        end
        ISSUE: state_d = WAIT;
        // After an accepted ack, WAIT lingers one cycle with cnt_en high so
        // CHECK sees the incremented count.
        WAIT: begin
          if (cnt_en_q) begin
            state_d = CHECK;
          end else if (dp_req_q && dp_ack) begin
            dp_req_d  = 1'b0;
            dp_last_d = 1'b0;
            cnt_en_d  = 1'b1;
`ifdef EULER_TIMEOUT_EN
          end else if (wd_expired) begin
            state_d   = ERROR;
            dp_req_d  = 1'b0;
            dp_last_d = 1'b0;
            err_d     = 1'b1;
`endif
          end
        end
        CHECK: begin
          if (cnt_value == num_steps_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ISSUE;
            dp_req_d  = 1'b1;
            dp_last_d = (cnt_value == num_steps_q - CNT_W'(1));
          end
        end
        DONE: state_d = IDLE;
`ifdef EULER_TIMEOUT_EN
        ERROR: begin
          if (start) begin
            err_d          = 1'b0;
            num_steps_d    = num_steps;
            cnt_sync_clr_d = 1'b1;
            state_d        = CLEAR;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    busy_d = !(state_d inside {IDLE, DONE, ERROR});
  end

  always_ff @(posedge clk or negedge rest_async_n) begin
    if (!rest_async_n) begin
      state_q        <= IDLE;
      num_steps_q    <= '0;
      cnt_sync_clr_q <= 1'b0;
      cnt_en_q       <= 1'b0;
      dp_req_q       <= 1'b0;
      dp_last_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef EULER_TIMEOUT_EN
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      num_steps_q    <= num_steps_d;
      cnt_sync_clr_q <= cnt_sync_clr_d;
      cnt_en_q       <= cnt_en_d;
      dp_req_q       <= dp_req_d;
      dp_last_q      <= dp_last_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef EULER_TIMEOUT_EN
      err_q          <= err_d;
`endif
    end
  end

  assign cnt_sync_clr = cnt_sync_clr_q;
  assign cnt_en       = cnt_en_q;
  assign dp_req       = dp_req_q;
  assign dp_last      = dp_last_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef EULER_TIMEOUT_EN
  assign err          = err_q;
`else
  // Timeout parameters are inert in this build; err is constant 0.
  assign err          = (TMO_CYC < 0) && (TMO_W < 0);
`endif

endmodule
